// File: rtl/qdr_port_arbiter.sv
// ---------------------------------------------------------------------------
// qdr_port_arbiter
//
// Two-port arbiter in front of the single-user QDR controller interface.
// Each cycle at most one read or write is granted (round-robin between port
// A and port B, only while phy_rdy is high). The granted command is
// registered onto the usr_* strobes/addr/data/be one cycle later. Every
// issued read pushes its port id into a tag FIFO; read data returned by the
// controller (usr_rd_dvld) pops the head tag and is steered, registered, to
// the port that issued it, preserving issue order.
//
// Build option:
//   QDR_ARB_FIXED_PRIO_EN  defined   -> port A has strict priority over B.
//                          undefined -> round-robin (default).
//
// Ports:
//   clk0, reset            clock (posedge), synchronous active-high reset
//   phy_rdy                controller calibrated; no grants while low
//   a_* / b_*              requester ports: rd/wr strobes held until ack,
//                          addr, write data, byte enables; ack (comb),
//                          registered read data + 1-cycle data valid
//   usr_*                  controller user interface (registered commands,
//                          read data/valid return)
//   arb_err                sticky: rd&wr on one port, or orphan read return
//
// Handshake: a request (rd|wr strobe) is held by the requester until x_ack
// is seen high in the same cycle; after an ack the requester may drop the
// request or present the next one in the following cycle.
// ---------------------------------------------------------------------------
module qdr_port_arbiter #(
    parameter int DATA_WIDTH = 18,
    parameter int BW_WIDTH   = 2,
    parameter int ADDR_WIDTH = 21,
    parameter int TAG_DEPTH  = 16
) (
    input  logic                    clk0,
    input  logic                    reset,
    input  logic                    phy_rdy,
    // port A
    input  logic                    a_rd_strb,
    input  logic                    a_wr_strb,
    input  logic [ADDR_WIDTH-1:0]   a_addr,
    input  logic [2*DATA_WIDTH-1:0] a_wr_data,
    input  logic [2*BW_WIDTH-1:0]   a_wr_be,
    output logic                    a_ack,
    output logic [2*DATA_WIDTH-1:0] a_rd_data,
    output logic                    a_rd_dvld,
    // port B
    input  logic                    b_rd_strb,
    input  logic                    b_wr_strb,
    input  logic [ADDR_WIDTH-1:0]   b_addr,
    input  logic [2*DATA_WIDTH-1:0] b_wr_data,
    input  logic [2*BW_WIDTH-1:0]   b_wr_be,
    output logic                    b_ack,
    output logic [2*DATA_WIDTH-1:0] b_rd_data,
    output logic                    b_rd_dvld,
    // controller user interface
    output logic                    usr_rd_strb,
    output logic                    usr_wr_strb,
    output logic [ADDR_WIDTH-1:0]   usr_addr,
    output logic [2*DATA_WIDTH-1:0] usr_wr_data,
    output logic [2*BW_WIDTH-1:0]   usr_wr_be,
    input  logic [2*DATA_WIDTH-1:0] usr_rd_data,
    input  logic                    usr_rd_dvld,
    output logic                    arb_err
);

    localparam int DW    = 2 * DATA_WIDTH;
    localparam int BW    = 2 * BW_WIDTH;
    localparam int PTR_W = (TAG_DEPTH > 1) ? $clog2(TAG_DEPTH) : 1;
    localparam int CNT_W = PTR_W + 1;

    // Tag values: 0 = port A, 1 = port B.
    logic                  usr_rd_strb_q, usr_rd_strb_d;
    logic                  usr_wr_strb_q, usr_wr_strb_d;
    logic [ADDR_WIDTH-1:0] usr_addr_q,    usr_addr_d;
    logic [DW-1:0]         usr_wr_data_q, usr_wr_data_d;
    logic [BW-1:0]         usr_wr_be_q,   usr_wr_be_d;
    logic [TAG_DEPTH-1:0]  tag_mem_q,     tag_mem_d;
    logic [PTR_W-1:0]      wr_ptr_q,      wr_ptr_d;
    logic [PTR_W-1:0]      rd_ptr_q,      rd_ptr_d;
    logic [CNT_W-1:0]      cnt_q,         cnt_d;
    logic                  a_rd_dvld_q,   a_rd_dvld_d;
    logic                  b_rd_dvld_q,   b_rd_dvld_d;
    logic [DW-1:0]         a_rd_data_q,   a_rd_data_d;
    logic [DW-1:0]         b_rd_data_q,   b_rd_data_d;
    logic                  arb_err_q,     arb_err_d;
`ifndef QDR_ARB_FIXED_PRIO_EN
    // 0 = A granted last, 1 = B granted last.
    logic                  last_grant_q,  last_grant_d;
`endif

    logic fifo_full, fifo_empty;
    logic a_rd_only, b_rd_only;
    logic a_elig, b_elig;
    logic gnt_a, gnt_b, gnt_any;
    logic sel_rd, sel_wr;
    logic push, pop, head_tag;

    always_comb begin
        fifo_full  = (cnt_q == CNT_W'(TAG_DEPTH));
        fifo_empty = (cnt_q == '0);

        // A pure read is the only request the tag FIFO can block; a write,
        // or rd&wr (which issues as a write), always stays eligible.
        a_rd_only = a_rd_strb & ~a_wr_strb;
        b_rd_only = b_rd_strb & ~b_wr_strb;
        a_elig    = (a_rd_strb | a_wr_strb) & phy_rdy & ~(a_rd_only & fifo_full);
        b_elig    = (b_rd_strb | b_wr_strb) & phy_rdy & ~(b_rd_only & fifo_full);

`ifdef QDR_ARB_FIXED_PRIO_EN
        gnt_a = a_elig;
        gnt_b = b_elig & ~a_elig;
`else
        if (a_elig && b_elig) begin
            gnt_a = last_grant_q;
            gnt_b = ~last_grant_q;
        end else begin
            gnt_a = a_elig;
            gnt_b = b_elig;
        end
`endif
        gnt_any = gnt_a | gnt_b;

        sel_rd = gnt_b ? b_rd_strb : a_rd_strb;
        sel_wr = gnt_b ? b_wr_strb : a_wr_strb;

        // Command register: strobes pulse for one cycle, payload holds.
        usr_rd_strb_d = gnt_any & sel_rd & ~sel_wr;
        usr_wr_strb_d = gnt_any & sel_wr;
        usr_addr_d    = usr_addr_q;
        usr_wr_data_d = usr_wr_data_q;
        usr_wr_be_d   = usr_wr_be_q;
        if (gnt_any) begin
            usr_addr_d    = gnt_b ? b_addr    : a_addr;
            usr_wr_data_d = gnt_b ? b_wr_data : a_wr_data;
            usr_wr_be_d   = gnt_b ? b_wr_be   : a_wr_be;
        end

`ifndef QDR_ARB_FIXED_PRIO_EN
        last_grant_d = gnt_any ? gnt_b : last_grant_q;
`endif

        // Tag FIFO
        push     = usr_rd_strb_d;
        pop      = usr_rd_dvld & ~fifo_empty;
        head_tag = tag_mem_q[rd_ptr_q];

        tag_mem_d = tag_mem_q;
        wr_ptr_d  = wr_ptr_q;
        rd_ptr_d  = rd_ptr_q;
        cnt_d     = cnt_q;
        if (push) begin
            tag_mem_d[wr_ptr_q] = gnt_b;
            wr_ptr_d            = wr_ptr_q + PTR_W'(1);
        end
        if (pop) begin
            rd_ptr_d = rd_ptr_q + PTR_W'(1);
        end
        if (push && !pop) begin
            cnt_d = cnt_q + CNT_W'(1);
        end else if (pop && !push) begin
            cnt_d = cnt_q - CNT_W'(1);
        end

        // Return steering: data registers hold when not written.
        a_rd_dvld_d = pop & ~head_tag;
        b_rd_dvld_d = pop & head_tag;
        a_rd_data_d = a_rd_dvld_d ? usr_rd_data : a_rd_data_q;
        b_rd_data_d = b_rd_dvld_d ? usr_rd_data : b_rd_data_q;

        arb_err_d = arb_err_q
                  | (gnt_any & sel_rd & sel_wr)
                  | (usr_rd_dvld & fifo_empty);
    end

    always_ff @(posedge clk0) begin
        if (reset) begin
            usr_rd_strb_q <= 1'b0;
            usr_wr_strb_q <= 1'b0;
            usr_addr_q    <= '0;
            usr_wr_data_q <= '0;
            usr_wr_be_q   <= '0;
            tag_mem_q     <= '0;
            wr_ptr_q      <= '0;
            rd_ptr_q      <= '0;
            cnt_q         <= '0;
            a_rd_dvld_q   <= 1'b0;
            b_rd_dvld_q   <= 1'b0;
            a_rd_data_q   <= '0;
            b_rd_data_q   <= '0;
            arb_err_q     <= 1'b0;
`ifndef QDR_ARB_FIXED_PRIO_EN
            last_grant_q  <= 1'b1;   // B, so A wins the first tie
`endif
        end else begin
            usr_rd_strb_q <= usr_rd_strb_d;
            usr_wr_strb_q <= usr_wr_strb_d;
            usr_addr_q    <= usr_addr_d;
            usr_wr_data_q <= usr_wr_data_d;
            usr_wr_be_q   <= usr_wr_be_d;
            tag_mem_q     <= tag_mem_d;
            wr_ptr_q      <= wr_ptr_d;
            rd_ptr_q      <= rd_ptr_d;
            cnt_q         <= cnt_d;
            a_rd_dvld_q   <= a_rd_dvld_d;
            b_rd_dvld_q   <= b_rd_dvld_d;
            a_rd_data_q   <= a_rd_data_d;
            b_rd_data_q   <= b_rd_data_d;
            arb_err_q     <= arb_err_d;
`ifndef QDR_ARB_FIXED_PRIO_EN
            last_grant_q  <= last_grant_d;
`endif
        end
    end

    assign a_ack       = gnt_a;
    assign b_ack       = gnt_b;
    assign usr_rd_strb = usr_rd_strb_q;
    assign usr_wr_strb = usr_wr_strb_q;
    assign usr_addr    = usr_addr_q;
    assign usr_wr_data = usr_wr_data_q;
    assign usr_wr_be   = usr_wr_be_q;
    assign a_rd_data   = a_rd_data_q;
    assign a_rd_dvld   = a_rd_dvld_q;
    assign b_rd_data   = b_rd_data_q;
    assign b_rd_dvld   = b_rd_dvld_q;
    assign arb_err     = arb_err_q;

endmodule

// File: tb/tb_qdr_port_arbiter.sv
// ---------------------------------------------------------------------------
// tb_qdr_port_arbiter
//
// Directed bench for qdr_port_arbiter. Expected controller commands and
// expected port read returns are pushed into queues when stimulus is
// issued; a forked monitor pops and compares them whenever the DUT shows a
// usr strobe or a port read-data valid. Timing-specific checks (acks,
// latencies, sticky error) are done inline by the driver.
// ---------------------------------------------------------------------------
module tb_qdr_port_arbiter;

    localparam int DATA_WIDTH = 18;
    localparam int BW_WIDTH   = 2;
    localparam int ADDR_WIDTH = 21;
    localparam int TAG_DEPTH  = 16;
    localparam int DW         = 2 * DATA_WIDTH;
    localparam int BW         = 2 * BW_WIDTH;
    localparam int CMD_W      = 2 + ADDR_WIDTH + DW + BW;
    localparam int RET_W      = 1 + DW;

    // ---------------- clock / reset ----------------
    logic clk0 = 1'b0;
    logic reset = 1'b1;
    always #5 clk0 = ~clk0;

    logic                  phy_rdy;
    logic                  a_rd_strb, a_wr_strb, a_ack, a_rd_dvld;
    logic [ADDR_WIDTH-1:0] a_addr;
    logic [DW-1:0]         a_wr_data, a_rd_data;
    logic [BW-1:0]         a_wr_be;
    logic                  b_rd_strb, b_wr_strb, b_ack, b_rd_dvld;
    logic [ADDR_WIDTH-1:0] b_addr;
    logic [DW-1:0]         b_wr_data, b_rd_data;
    logic [BW-1:0]         b_wr_be;
    logic                  usr_rd_strb, usr_wr_strb, usr_rd_dvld, arb_err;
    logic [ADDR_WIDTH-1:0] usr_addr;
    logic [DW-1:0]         usr_wr_data, usr_rd_data;
    logic [BW-1:0]         usr_wr_be;

    qdr_port_arbiter #(
        .DATA_WIDTH(DATA_WIDTH), .BW_WIDTH(BW_WIDTH),
        .ADDR_WIDTH(ADDR_WIDTH), .TAG_DEPTH(TAG_DEPTH)
    ) dut (
        .clk0(clk0), .reset(reset), .phy_rdy(phy_rdy),
        .a_rd_strb(a_rd_strb), .a_wr_strb(a_wr_strb), .a_addr(a_addr),
        .a_wr_data(a_wr_data), .a_wr_be(a_wr_be), .a_ack(a_ack),
        .a_rd_data(a_rd_data), .a_rd_dvld(a_rd_dvld),
        .b_rd_strb(b_rd_strb), .b_wr_strb(b_wr_strb), .b_addr(b_addr),
        .b_wr_data(b_wr_data), .b_wr_be(b_wr_be), .b_ack(b_ack),
        .b_rd_data(b_rd_data), .b_rd_dvld(b_rd_dvld),
        .usr_rd_strb(usr_rd_strb), .usr_wr_strb(usr_wr_strb),
        .usr_addr(usr_addr), .usr_wr_data(usr_wr_data), .usr_wr_be(usr_wr_be),
        .usr_rd_data(usr_rd_data), .usr_rd_dvld(usr_rd_dvld),
        .arb_err(arb_err)
    );

    // ---------------- scoreboard ----------------
    logic [CMD_W-1:0] exp_q[$];
    logic [RET_W-1:0] ret_q[$];
    int n_vec = 0;
    int n_err = 0;
    int wr_pulses = 0;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h, expected %0h (t=%0t)", name, act, exp, $time);
        end
    endtask

    function automatic logic [CMD_W-1:0] mk_cmd(input logic rd, input logic wr,
                                                 input logic [ADDR_WIDTH-1:0] addr,
                                                 input logic [DW-1:0] data,
                                                 input logic [BW-1:0] be);
        return {rd, wr, addr, data, be};
    endfunction

    task automatic monitor();
        logic [CMD_W-1:0] exp_c;
        logic [RET_W-1:0] exp_r;
        forever begin
            @(negedge clk0);
            if (!reset) begin
                if (usr_rd_strb || usr_wr_strb) begin
                    if (usr_wr_strb) wr_pulses++;
                    if (exp_q.size() == 0) begin
                        n_vec++; n_err++;
                        $display("FAIL unexpected_cmd: got rd=%0b wr=%0b addr=%0h, expected none",
                                 usr_rd_strb, usr_wr_strb, usr_addr);
                    end else begin
                        exp_c = exp_q.pop_front();
                        check("usr_cmd", 64'({usr_rd_strb, usr_wr_strb, usr_addr, usr_wr_data, usr_wr_be}),
                              64'(exp_c));
                    end
                end
                if (a_rd_dvld && b_rd_dvld) begin
                    n_vec++; n_err++;
                    $display("FAIL both_dvld: got a=1 b=1, expected at most one");
                end else if (a_rd_dvld || b_rd_dvld) begin
                    if (ret_q.size() == 0) begin
                        n_vec++; n_err++;
                        $display("FAIL unexpected_ret: got a=%0b b=%0b, expected none", a_rd_dvld, b_rd_dvld);
                    end else begin
                        exp_r = ret_q.pop_front();
                        check("rd_return", 64'({b_rd_dvld, b_rd_dvld ? b_rd_data : a_rd_data}), 64'(exp_r));
                    end
                end
            end
        end
    endtask

    // ---------------- driver tasks ----------------
    task automatic clear_req();
        a_rd_strb = 1'b0; a_wr_strb = 1'b0; a_addr = '0; a_wr_data = '0; a_wr_be = '0;
        b_rd_strb = 1'b0; b_wr_strb = 1'b0; b_addr = '0; b_wr_data = '0; b_wr_be = '0;
        usr_rd_dvld = 1'b0; usr_rd_data = '0;
    endtask

    task automatic reset_dut();
        @(negedge clk0);
        reset = 1'b1;
        clear_req();
        repeat (2) @(negedge clk0);
        reset = 1'b0;
    endtask

    // Watchdog: the run is lockstep, this only guards against a stuck sim.
    initial begin
        #200000;
        $display("FAIL watchdog: got timeout, expected completion");
        $fatal(1, "timeout");
    end

    logic [DW-1:0] d_ret [3];
    logic          exp_a_ret [3];
    int a_idx, b_idx, wr_base;
    logic exp_a;

    initial begin
        fork
            monitor();
        join_none

        // ---- reset state ----
        phy_rdy = 1'b0;
        clear_req();
        reset = 1'b1;
        repeat (3) @(negedge clk0);
        #1;
        check("rst_usr_rd_strb", 64'(usr_rd_strb), 64'd0);
        check("rst_usr_wr_strb", 64'(usr_wr_strb), 64'd0);
        check("rst_usr_addr",    64'(usr_addr),    64'd0);
        check("rst_arb_err",     64'(arb_err),     64'd0);
        check("rst_a_rd_dvld",   64'(a_rd_dvld),   64'd0);
        check("rst_b_rd_dvld",   64'(b_rd_dvld),   64'd0);
        check("rst_a_rd_data",   64'(a_rd_data),   64'd0);
        reset = 1'b0;

        // ---- 1: no grant while phy_rdy low ----
        for (int i = 0; i < 3; i++) begin
            @(negedge clk0);
            a_rd_strb = 1'b1; a_addr = 21'h111; a_wr_data = 36'h5; a_wr_be = 4'h3;
            #1 check("t1_no_ack_phy_low", 64'(a_ack), 64'd0);
        end
        @(negedge clk0);
        phy_rdy = 1'b1;
        #1 check("t1_ack_at_T", 64'(a_ack), 64'd1);
        exp_q.push_back(mk_cmd(1'b1, 1'b0, 21'h111, 36'h5, 4'h3));
        @(negedge clk0);
        a_rd_strb = 1'b0;
        #1 check("t1_rd_strb_T1", 64'(usr_rd_strb), 64'd1);
        @(negedge clk0);
        #1 check("t1_rd_strb_T2", 64'(usr_rd_strb), 64'd0);
        @(negedge clk0);
        usr_rd_dvld = 1'b1; usr_rd_data = 36'h0_1111_2222;
        ret_q.push_back({1'b0, 36'h0_1111_2222});
        @(negedge clk0);
        usr_rd_dvld = 1'b0;
        #1 check("t1_a_dvld_R1", 64'(a_rd_dvld), 64'd1);
        check("t1_b_dvld_R1", 64'(b_rd_dvld), 64'd0);
        @(negedge clk0);
        #1 check("t1_a_dvld_R2", 64'(a_rd_dvld), 64'd0);

        // ---- 2: both ports write continuously ----
        reset_dut();
        a_idx = 0; b_idx = 0;
        wr_base = wr_pulses;
        for (int i = 0; i < 8; i++) begin
            @(negedge clk0);
            a_wr_strb = (a_idx < 4); a_addr = 21'h100 + 21'(a_idx);
            a_wr_data = 36'hA0000 + 36'(a_idx); a_wr_be = 4'h5;
            b_wr_strb = (b_idx < 4); b_addr = 21'h200 + 21'(b_idx);
            b_wr_data = 36'hB0000 + 36'(b_idx); b_wr_be = 4'hA;
`ifdef QDR_ARB_FIXED_PRIO_EN
            exp_a = (a_idx < 4);
`else
            exp_a = (i % 2 == 0);
`endif
            #1;
            check("t2_a_ack", 64'(a_ack), 64'(exp_a));
            check("t2_b_ack", 64'(b_ack), 64'(!exp_a));
            if (exp_a) begin
                exp_q.push_back(mk_cmd(1'b0, 1'b1, 21'h100 + 21'(a_idx), 36'hA0000 + 36'(a_idx), 4'h5));
                a_idx++;
            end else begin
                exp_q.push_back(mk_cmd(1'b0, 1'b1, 21'h200 + 21'(b_idx), 36'hB0000 + 36'(b_idx), 4'hA));
                b_idx++;
            end
        end
        @(negedge clk0);
        clear_req();
        repeat (2) @(negedge clk0);
        #1 check("t2_wr_pulses", 64'(wr_pulses - wr_base), 64'd8);

        // ---- 3: in-order return steering, phy_rdy drop while draining ----
        d_ret[0] = 36'h1_2345_6789; d_ret[1] = 36'hA_BCDE_F012; d_ret[2] = 36'h0_F0F0_F0F0;
        exp_a_ret[0] = 1'b1; exp_a_ret[1] = 1'b0; exp_a_ret[2] = 1'b1;
        @(negedge clk0);
        a_rd_strb = 1'b1; a_addr = 21'h10;
        #1 check("t3_a_ack_0x10", 64'(a_ack), 64'd1);
        exp_q.push_back(mk_cmd(1'b1, 1'b0, 21'h10, '0, '0));
        @(negedge clk0);
        a_rd_strb = 1'b0; b_rd_strb = 1'b1; b_addr = 21'h20;
        #1 check("t3_b_ack_0x20", 64'(b_ack), 64'd1);
        exp_q.push_back(mk_cmd(1'b1, 1'b0, 21'h20, '0, '0));
        @(negedge clk0);
        b_rd_strb = 1'b0; a_rd_strb = 1'b1; a_addr = 21'h30;
        #1 check("t3_a_ack_0x30", 64'(a_ack), 64'd1);
        exp_q.push_back(mk_cmd(1'b1, 1'b0, 21'h30, '0, '0));
        @(negedge clk0);
        a_rd_strb = 1'b0; phy_rdy = 1'b0;
        b_wr_strb = 1'b1; b_addr = 21'h40; b_wr_data = 36'h4444; b_wr_be = 4'hF;
        #1 check("t3_b_ack_phy_low", 64'(b_ack), 64'd0);
        for (int k = 0; k < 4; k++) begin
            @(negedge clk0);
            #1;
            if (k > 0) begin
                check("t3_a_dvld", 64'(a_rd_dvld), 64'(exp_a_ret[k-1]));
                check("t3_b_dvld", 64'(b_rd_dvld), 64'(!exp_a_ret[k-1]));
            end
            check("t3_b_ack_held", 64'(b_ack), 64'd0);
            if (k < 3) begin
                usr_rd_dvld = 1'b1; usr_rd_data = d_ret[k];
                ret_q.push_back({!exp_a_ret[k], d_ret[k]});
            end else begin
                usr_rd_dvld = 1'b0;
            end
        end
        @(negedge clk0);
        #1 check("t3_a_data_hold", 64'(a_rd_data), 64'(d_ret[2]));
        check("t3_b_data_hold", 64'(b_rd_data), 64'(d_ret[1]));
        phy_rdy = 1'b1;
        #1 check("t3_b_ack_phy_back", 64'(b_ack), 64'd1);
        exp_q.push_back(mk_cmd(1'b0, 1'b1, 21'h40, 36'h4444, 4'hF));
        @(negedge clk0);
        clear_req();

        // ---- 4: tag FIFO full ----
        for (int i = 0; i < TAG_DEPTH; i++) begin
            @(negedge clk0);
            a_rd_strb = 1'b1; a_addr = 21'h300 + 21'(i);
            #1 check("t4_fill_ack", 64'(a_ack), 64'd1);
            exp_q.push_back(mk_cmd(1'b1, 1'b0, 21'h300 + 21'(i), '0, '0));
        end
        @(negedge clk0);
        a_rd_strb = 1'b1; a_addr = 21'h3FF;
        b_wr_strb = 1'b1; b_addr = 21'h400; b_wr_data = 36'h9999; b_wr_be = 4'h1;
        #1 check("t4_rd_blocked_full", 64'(a_ack), 64'd0);
        check("t4_wr_ok_full", 64'(b_ack), 64'd1);
        exp_q.push_back(mk_cmd(1'b0, 1'b1, 21'h400, 36'h9999, 4'h1));
        @(negedge clk0);
        b_wr_strb = 1'b0; b_addr = '0; b_wr_data = '0; b_wr_be = '0;
        usr_rd_dvld = 1'b1; usr_rd_data = 36'hE0000;
        ret_q.push_back({1'b0, 36'hE0000});
        #1 check("t4_still_full_on_pop", 64'(a_ack), 64'd0);
        @(negedge clk0);
        usr_rd_dvld = 1'b0;
        #1 check("t4_ack_after_pop", 64'(a_ack), 64'd1);
        exp_q.push_back(mk_cmd(1'b1, 1'b0, 21'h3FF, '0, '0));
        @(negedge clk0);
        a_rd_strb = 1'b0; a_addr = '0;
        for (int j = 1; j <= TAG_DEPTH; j++) begin
            usr_rd_dvld = 1'b1; usr_rd_data = 36'hE0000 + 36'(j);
            ret_q.push_back({1'b0, 36'hE0000 + 36'(j)});
            @(negedge clk0);
        end
        usr_rd_dvld = 1'b0;
        repeat (2) @(negedge clk0);

        // ---- 5: orphan return and rd&wr collision ----
        usr_rd_dvld = 1'b1; usr_rd_data = 36'hDEAD;
        @(negedge clk0);
        usr_rd_dvld = 1'b0;
        #1 check("t5_orphan_a_dvld", 64'(a_rd_dvld), 64'd0);
        check("t5_orphan_b_dvld", 64'(b_rd_dvld), 64'd0);
        check("t5_orphan_err", 64'(arb_err), 64'd1);
        repeat (3) @(negedge clk0);
        #1 check("t5_err_sticky", 64'(arb_err), 64'd1);
        reset_dut();
        #1 check("t5_err_cleared", 64'(arb_err), 64'd0);
        @(negedge clk0);
        a_rd_strb = 1'b1; a_wr_strb = 1'b1; a_addr = 21'h55; a_wr_data = 36'h5555; a_wr_be = 4'hC;
        #1 check("t5_rdwr_ack", 64'(a_ack), 64'd1);
        exp_q.push_back(mk_cmd(1'b0, 1'b1, 21'h55, 36'h5555, 4'hC));
        @(negedge clk0);
        clear_req();
        #1 check("t5_rdwr_err", 64'(arb_err), 64'd1);
        check("t5_rdwr_no_rd", 64'(usr_rd_strb), 64'd0);
        repeat (3) @(negedge clk0);

        // ---- end of run ----
        check("end_cmd_q_empty", 64'(exp_q.size()), 64'd0);
        check("end_ret_q_empty", 64'(ret_q.size()), 64'd0);
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
